// File: rtl/mips32_pkg.sv
// rtl/mips32_pkg.sv - shared MIPS32 opcodes, instruction types, field helpers and fetch-queue types
package mips32_pkg;

    localparam logic [5:0] ADD   = 6'b000000;
    localparam logic [5:0] SUB   = 6'b000001;
    localparam logic [5:0] AND   = 6'b000010;
    localparam logic [5:0] OR    = 6'b000011;
    localparam logic [5:0] SLT   = 6'b000100;
    localparam logic [5:0] MUL   = 6'b000101;
    localparam logic [5:0] LW    = 6'b001000;
    localparam logic [5:0] SW    = 6'b001001;
    localparam logic [5:0] ADDI  = 6'b001010;
    localparam logic [5:0] SUBI  = 6'b001011;
    localparam logic [5:0] SLTI  = 6'b001100;
    localparam logic [5:0] BNEQZ = 6'b001101;
    localparam logic [5:0] BEQZ  = 6'b001110;
    localparam logic [5:0] HLT   = 6'b111111;

    typedef enum logic [2:0] {
        RR_ALU,
        RM_ALU,
        LOAD,
        STORE,
        BRANCH,
        HALT
    } instr_type_t;

    typedef enum logic {
        FETCH,
        HALTED
    } ifq_state_t;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] npc;
    } ifq_entry_t;

    function automatic logic [5:0] f_opcode(input logic [31:0] ir);
        return ir[31:26];
    endfunction

    function automatic logic [4:0] f_rs(input logic [31:0] ir);
        return ir[25:21];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] ir);
        return ir[20:16];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] ir);
        return ir[15:11];
    endfunction

    function automatic logic [15:0] f_imm(input logic [31:0] ir);
        return ir[15:0];
    endfunction

    function automatic instr_type_t decode_type(input logic [5:0] op);
        instr_type_t t;
        case (op)
            ADD, SUB, AND, OR, SLT, MUL: t = RR_ALU;
            ADDI, SUBI, SLTI:            t = RM_ALU;
            LW:                          t = LOAD;
            SW:                          t = STORE;
            BNEQZ, BEQZ:                 t = BRANCH;
            HLT:                         t = HALT;
            default:                     t = RR_ALU;
        endcase
        return t;
    endfunction

    // Saturating 32-bit accumulate used by the performance counters.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] inc);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, inc};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/mips32_sync_fifo.sv
// rtl/mips32_sync_fifo.sv - synchronous FIFO with clear, count and first-word-fall-through head
module mips32_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk1,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == (AW + 1)'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk1) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; clear empties the FIFO in one cycle.
    always_ff @(posedge clk1) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mips32_ifetch_queue.sv
// rtl/mips32_ifetch_queue.sv - MIPS32 instruction prefetch queue; optional IFQ_PERF_EN adds perf counters
module mips32_ifetch_queue #(
    parameter int DEPTH    = 4,
    parameter int MAX_OUT  = 2,
    parameter int ADDR_W   = 10,
    parameter int RESET_PC = 0
) (
    input  logic              clk1,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [31:0]       id_ir,
    output logic [31:0]       id_npc,
    output logic              halted
`ifdef IFQ_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_flushed
`endif
);

    import mips32_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUT) + 1;
    localparam int SW = ((CW > OW) ? CW : OW) + 1;

    ifq_state_t        state;
    ifq_state_t        state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] rsp_pc;
    logic [OW-1:0]     out_cnt;
    logic [OW-1:0]     out_next;
    logic [OW-1:0]     drop_cnt;
    logic [OW-1:0]     drop_next;
    logic [CW-1:0]     fifo_cnt;
    logic [SW-1:0]     credit_sum;
    logic              fifo_empty;
    logic              rsp_drop;
    logic              push;
    logic              pop;
    logic              push_is_hlt;
    logic [31:0]       push_npc;
    ifq_entry_t        push_entry;
    ifq_entry_t        head_entry;

    // A response is discarded while stale requests are still draining.
    assign rsp_drop    = imem_rvalid && (drop_cnt != '0);
    assign push        = imem_rvalid && (drop_cnt == '0) && !redirect_valid;
    assign pop         = !fifo_empty && id_ready && !redirect_valid;
    assign push_is_hlt = push && (f_opcode(imem_rdata) == HLT);
    // Every outstanding request owns a FIFO slot, so push can never overflow.
    assign credit_sum  = SW'(fifo_cnt) + SW'(out_cnt);
    assign push_npc    = 32'(rsp_pc) + 32'd1;
    assign push_entry  = '{ir: imem_rdata, npc: push_npc};

    assign imem_addr = pc;
    assign id_valid  = !fifo_empty;
    assign id_ir     = head_entry.ir;
    assign id_npc    = head_entry.npc;
    assign halted    = (state == HALTED);

    mips32_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(ifq_entry_t))
    ) u_fifo (
        .clk1      (clk1),
        .rst       (rst),
        .clear     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

    // Request issue, next state and drop bookkeeping; redirect outranks HLT.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        if (!rst && (state == FETCH) && !redirect_valid &&
            (out_cnt < OW'(MAX_OUT)) && (credit_sum < SW'(DEPTH))) begin
            imem_req = 1'b1;
        end
        out_next  = out_cnt + OW'(imem_req) - OW'(imem_rvalid);
        drop_next = drop_cnt;
        if (redirect_valid) begin
            state_next = FETCH;
            drop_next  = out_next;
        end else if (push_is_hlt) begin
            state_next = HALTED;
            drop_next  = out_next;
        end else if (rsp_drop) begin
            drop_next = drop_cnt - OW'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Fetch/response address pointers and in-flight counters.
    always_ff @(posedge clk1) begin
        if (rst) begin
            pc       <= ADDR_W'(RESET_PC);
            rsp_pc   <= ADDR_W'(RESET_PC);
            out_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            out_cnt  <= out_next;
            drop_cnt <= drop_next;
            if (redirect_valid) begin
                pc     <= redirect_pc;
                rsp_pc <= redirect_pc;
            end else begin
                if (imem_req) begin
                    pc <= pc + ADDR_W'(1);
                end
                if (push) begin
                    rsp_pc <= rsp_pc + ADDR_W'(1);
                end
            end
        end
    end

`ifdef IFQ_PERF_EN
    logic [31:0] flush_inc;

    assign flush_inc = redirect_valid ? (32'(fifo_cnt) + 32'(imem_rvalid)) : 32'(rsp_drop);

    // Saturating counts of delivered and discarded instructions.
    always_ff @(posedge clk1) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            perf_fetched <= sat_add32(perf_fetched, 32'(pop));
            perf_flushed <= sat_add32(perf_flushed, flush_inc);
        end
    end
`endif

    // A response with nothing outstanding means the memory broke its protocol.
    ifq_no_orphan_rsp: assert property (@(posedge clk1) disable iff (rst)
        imem_rvalid |-> (out_cnt != '0));

endmodule
